// File: rtl/replica_pkg.sv
// replica_pkg: shared types and constants for the replica AXI4-Lite master
package replica_pkg;

    localparam int AXIM_ADDR_W = 32;
    localparam int AXIM_DATA_W = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        AXIM_WRITE = 2'd0,
        AXIM_READ  = 2'd1,
        AXIM_POLL  = 2'd2
    } axim_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_GAP,
        ST_RSP
    } axim_state_t;

    typedef struct packed {
        axim_op_t                   op;
        logic [AXIM_ADDR_W-1:0]     addr;
        logic [AXIM_DATA_W-1:0]     wdata;
        logic [AXIM_DATA_W/8-1:0]   wstrb;
        logic [AXIM_DATA_W-1:0]     match;
    } axim_cmd_t;

    // The reserved opcode behaves as a plain read.
    function automatic axim_op_t axim_decode(input logic [1:0] op);
        return (op == 2'd3) ? AXIM_READ : axim_op_t'(op);
    endfunction

endpackage

// File: rtl/replica_axi_master.sv
// replica_axi_master: command-driven AXI4-Lite master issuing single writes, reads and poll-until-match reads
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN      clock, synchronous active-low reset
//   cmd_*                           command channel (op, addr, wdata/mask, wstrb, match)
//   rsp_*                           response channel (data, resp, timeout)
//   busy                            high from command accept until response consumed
//   M_AXI_AW*/W*/B*/AR*/R*          AXI4-Lite master channels
module replica_axi_master
    import replica_pkg::*;
#(
    parameter int          ADDR_W   = AXIM_ADDR_W,
    parameter int          DATA_W   = AXIM_DATA_W,
    parameter int          POLL_GAP = 16,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    input  logic [DATA_W-1:0]   cmd_match,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam logic [15:0] GAP_INIT = 16'(POLL_GAP - 1);

    axim_state_t state, state_n;
    axim_cmd_t   cmd_q;
    logic        aw_done, w_done;
    logic [23:0] poll_cnt, cnt_n;
    logic [15:0] gap_cnt;
    logic        hit, poll_last, timeout_hit;

    assign cnt_n       = poll_cnt + 24'd1;
    assign hit         = (M_AXI_RDATA & cmd_q.wdata) == cmd_q.match;
    // A poll ends on a match, a slave error, or when this read exhausts the budget.
    assign poll_last   = cmd_q.op != AXIM_POLL || M_AXI_RRESP != AXI_RESP_OKAY || hit || cnt_n == POLL_MAX;
    assign timeout_hit = cmd_q.op == AXIM_POLL && M_AXI_RRESP == AXI_RESP_OKAY && !hit && cnt_n == POLL_MAX;

    assign cmd_ready     = state == ST_IDLE;
    assign busy          = state != ST_IDLE;
    assign rsp_valid     = state == ST_RSP;
    assign M_AXI_AWVALID = state == ST_WADDR && !aw_done;
    assign M_AXI_WVALID  = state == ST_WADDR && !w_done;
    assign M_AXI_BREADY  = state == ST_WRESP;
    assign M_AXI_ARVALID = state == ST_RADDR;
    assign M_AXI_RREADY  = state == ST_RDATA;
    assign M_AXI_AWADDR  = cmd_q.addr;
    assign M_AXI_ARADDR  = cmd_q.addr;
    assign M_AXI_WDATA   = cmd_q.wdata;
    assign M_AXI_WSTRB   = cmd_q.wstrb;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_n = (axim_decode(cmd_op) == AXIM_WRITE) ? ST_WADDR : ST_RADDR;
            ST_WADDR: if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_n = ST_WRESP;
            ST_WRESP: if (M_AXI_BVALID) state_n = ST_RSP;
            ST_RADDR: if (M_AXI_ARREADY) state_n = ST_RDATA;
            ST_RDATA: if (M_AXI_RVALID) state_n = poll_last ? ST_RSP : ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_n = ST_RADDR;
            ST_RSP:   if (rsp_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            cmd_q       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            rsp_data    <= '0;
            rsp_resp    <= AXI_RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q       <= '{op: axim_decode(cmd_op), addr: cmd_addr, wdata: cmd_wdata,
                                         wstrb: cmd_wstrb, match: cmd_match};
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        poll_cnt    <= '0;
                        rsp_timeout <= 1'b0;
                    end
                end
                ST_WADDR: begin
                    if (M_AXI_AWREADY) aw_done <= 1'b1;
                    if (M_AXI_WREADY) w_done <= 1'b1;
                end
                ST_WRESP: begin
                    if (M_AXI_BVALID) begin
                        rsp_data <= '0;
                        rsp_resp <= M_AXI_BRESP;
                    end
                end
                ST_RDATA: begin
                    if (M_AXI_RVALID) begin
                        rsp_data    <= M_AXI_RDATA;
                        rsp_resp    <= timeout_hit ? AXI_RESP_SLVERR : M_AXI_RRESP;
                        rsp_timeout <= timeout_hit;
                        if (!poll_last) begin
                            poll_cnt <= cnt_n;
                            gap_cnt  <= GAP_INIT;
                        end
                    end
                end
                ST_GAP: gap_cnt <= gap_cnt - 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_replica_axi_master.sv
// tb_replica_axi_master: scoreboard bench for replica_axi_master against a delay-configurable AXI4-Lite slave model
`timescale 1ns/1ps
module tb_replica_axi_master;

    localparam int POLL_GAP = 16;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0, cmd_match = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0, n_err = 0;

    rsp_t        exp_rsp[$];
    logic [31:0] exp_aw[$], obs_aw[$], obs_ar[$];
    logic [71:0] exp_w[$], obs_w[$];
    logic [65:0] rq[$];
    int          ar_cyc_q[$];

    int   aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  b_resp = 2'b00;
    logic [63:0] r_default = 64'd0;
    int   cyc = 0, aw_cyc = 0, w_cyc = 0, ar_viol = 0;
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit   aw_got, w_got, b_pend, r_pend, b_fire, r_fire, prev_arv, prev_arf;
    logic [31:0] prev_ara;
    logic [65:0] r_cur;

    always #5 clk = ~clk;

    replica_axi_master #(.POLL_GAP(POLL_GAP), .POLL_MAX(24'd4)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_match(cmd_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave model: decides its outputs just after each falling edge, so a handshake
    // seen here is the one the DUT takes on the next rising edge.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (!rstn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0; prev_arv = 0; prev_arf = 0;
            end else begin
                if (b_fire) begin bvalid = 0; b_fire = 0; end
                if (b_pend && !bvalid) begin
                    if (b_cnt == b_delay) begin bvalid = 1; bresp = b_resp; b_pend = 0; end
                    else b_cnt++;
                end
                b_fire = bvalid && bready;
                if (r_fire) begin rvalid = 0; r_fire = 0; end
                if (r_pend && !rvalid) begin
                    if (r_cnt == r_delay) begin rvalid = 1; {rresp, rdata} = r_cur; r_pend = 0; end
                    else r_cnt++;
                end
                r_fire = rvalid && rready;
                awready = awvalid && aw_cnt == aw_delay;
                if (awready) begin obs_aw.push_back(awaddr); aw_cyc = cyc; aw_cnt = 0; aw_got = 1; end
                else if (awvalid) aw_cnt++;
                wready = wvalid && w_cnt == w_delay;
                if (wready) begin obs_w.push_back({wdata, wstrb}); w_cyc = cyc; w_cnt = 0; w_got = 1; end
                else if (wvalid) w_cnt++;
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
                if (prev_arv && !prev_arf && (!arvalid || araddr !== prev_ara)) ar_viol++;
                arready = arvalid && ar_cnt == ar_delay;
                if (arready) begin
                    obs_ar.push_back(araddr); ar_cyc_q.push_back(cyc); ar_cnt = 0;
                    r_pend = 1; r_cnt = 0;
                    r_cur = (rq.size() > 0) ? rq.pop_front() : {2'b00, r_default};
                end else if (arvalid) ar_cnt++;
                prev_arv = arvalid; prev_arf = arready; prev_ara = araddr;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] wd,
                            input logic [7:0] st, input logic [63:0] m);
        int k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_match = m;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input string name, output int busy_low);
        int k = 0;
        busy_low = 0;
        while (!rsp_valid && k < 500) begin
            if (!busy) busy_low++;
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            n_cmp++; n_err++;
            $display("FAIL %s_rsp_wait: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, k);
        end
    endtask

    task automatic consume();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic clear_obs();
        obs_aw.delete(); obs_w.delete(); obs_ar.delete(); ar_cyc_q.delete();
        exp_aw.delete(); exp_w.delete(); rq.delete();
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, busy, cmd_ready} !== 9'b000000001) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 000000001",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, busy, cmd_ready});
        end
        n_cmp++;
        if ({rsp_data, rsp_resp} !== 66'd0) begin
            n_err++; $display("FAIL reset_rsp: data=%h resp=%b, required 0", rsp_data, rsp_resp);
        end
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_write();
        rsp_t e;
        int bl;
        logic [31:0] a;
        logic [71:0] w;
        clear_obs();
        aw_delay = 3; w_delay = 0; b_delay = 0; b_resp = 2'b00;
        exp_aw.push_back(32'h10);
        exp_w.push_back({64'h0123_4567_89AB_CDEF, 8'hFF});
        exp_rsp.push_back('{64'd0, 2'b00, 1'b0});
        send_cmd(2'd0, 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0);
        wait_rsp("write", bl);
        e = exp_rsp.pop_front();
        n_cmp++;
        if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
            n_err++; $display("FAIL write_rsp: data=%h resp=%b tmo=%b, required %h %b %b",
                              rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
        end
        consume();
        n_cmp++;
        if (obs_aw.size() != 1 || obs_w.size() != 1) begin
            n_err++; $display("FAIL write_beats: aw=%0d w=%0d, required 1 1", obs_aw.size(), obs_w.size());
        end else begin
            a = obs_aw.pop_front(); w = obs_w.pop_front();
            n_cmp++;
            if (a !== exp_aw.pop_front()) begin n_err++; $display("FAIL write_awaddr: got %h, required 00000010", a); end
            n_cmp++;
            if (w !== exp_w.pop_front()) begin n_err++; $display("FAIL write_wbeat: got %h, required 0123456789abcdefff", w); end
            n_cmp++;
            if (aw_cyc - w_cyc != 3) begin n_err++; $display("FAIL write_aw_after_w: got %0d, required 3", aw_cyc - w_cyc); end
        end
    endtask

    task automatic test_read();
        rsp_t e;
        int bl, v0;
        clear_obs();
        ar_delay = 2; r_delay = 5;
        v0 = ar_viol;
        rq.push_back({2'b00, 64'hDEAD_BEEF_0000_0001});
        exp_rsp.push_back('{64'hDEAD_BEEF_0000_0001, 2'b00, 1'b0});
        send_cmd(2'd1, 32'h20, 64'd0, 8'd0, 64'd0);
        wait_rsp("read", bl);
        e = exp_rsp.pop_front();
        n_cmp++;
        if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
            n_err++; $display("FAIL read_rsp: data=%h resp=%b tmo=%b, required %h %b %b",
                              rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
        end
        n_cmp++;
        if (bl != 0) begin n_err++; $display("FAIL read_busy: busy low %0d cycles, required 0", bl); end
        n_cmp++;
        if (ar_viol != v0) begin n_err++; $display("FAIL read_ar_stable: %0d violations, required 0", ar_viol - v0); end
        n_cmp++;
        if (obs_ar.size() != 1 || obs_ar[0] !== 32'h20) begin
            n_err++; $display("FAIL read_araddr: count=%0d, required one beat at 00000020", obs_ar.size());
        end
        consume();
    endtask

    task automatic test_poll_match();
        rsp_t e;
        int bl, bad = 0;
        clear_obs();
        ar_delay = 0; r_delay = 0;
        rq.push_back({2'b00, 64'd1}); rq.push_back({2'b00, 64'd1}); rq.push_back({2'b00, 64'd0});
        exp_rsp.push_back('{64'd0, 2'b00, 1'b0});
        send_cmd(2'd2, 32'h08, 64'd1, 8'd0, 64'd0);
        wait_rsp("poll_match", bl);
        e = exp_rsp.pop_front();
        n_cmp++;
        if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
            n_err++; $display("FAIL poll_match_rsp: data=%h resp=%b tmo=%b, required %h %b %b",
                              rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
        end
        n_cmp++;
        if (obs_ar.size() != 3) begin n_err++; $display("FAIL poll_match_reads: got %0d, required 3", obs_ar.size()); end
        foreach (obs_ar[i]) if (obs_ar[i] !== 32'h08) bad++;
        for (int i = 1; i < ar_cyc_q.size(); i++) if (ar_cyc_q[i] - ar_cyc_q[i-1] < POLL_GAP + 1) bad++;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL poll_match_spacing: %0d bad beats, required 0", bad); end
        consume();
    endtask

    task automatic test_poll_timeout();
        rsp_t e;
        int bl;
        clear_obs();
        r_default = 64'd1;
        exp_rsp.push_back('{64'd1, 2'b10, 1'b1});
        send_cmd(2'd2, 32'h08, 64'd1, 8'd0, 64'd0);
        wait_rsp("poll_timeout", bl);
        e = exp_rsp.pop_front();
        n_cmp++;
        if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
            n_err++; $display("FAIL poll_timeout_rsp: data=%h resp=%b tmo=%b, required %h %b %b",
                              rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
        end
        n_cmp++;
        if (obs_ar.size() != 4) begin n_err++; $display("FAIL poll_timeout_reads: got %0d, required 4", obs_ar.size()); end
        consume();
        r_default = 64'd0;
    endtask

    task automatic test_poll_error_hold();
        rsp_t e;
        int bl, unstable = 0;
        logic [63:0] d0;
        logic [1:0] r0;
        clear_obs();
        rq.push_back({2'b00, 64'd1}); rq.push_back({2'b10, 64'd5}); rq.push_back({2'b00, 64'd0});
        exp_rsp.push_back('{64'd5, 2'b10, 1'b0});
        send_cmd(2'd2, 32'h18, 64'd1, 8'd0, 64'd0);
        wait_rsp("poll_err", bl);
        e = exp_rsp.pop_front();
        d0 = rsp_data; r0 = rsp_resp;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_resp !== r0 || cmd_ready !== 1'b0) unstable++;
        end
        n_cmp++;
        if (unstable != 0) begin n_err++; $display("FAIL poll_err_hold: %0d unstable cycles, required 0", unstable); end
        n_cmp++;
        if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
            n_err++; $display("FAIL poll_err_rsp: data=%h resp=%b tmo=%b, required %h %b %b",
                              rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
        end
        n_cmp++;
        if (obs_ar.size() != 2) begin n_err++; $display("FAIL poll_err_reads: got %0d, required 2", obs_ar.size()); end
        consume();
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        int bl;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0] s;
        logic [1:0] r;
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            a = 32'h100 + 32'(i * 8);
            d = {$urandom, $urandom};
            s = 8'($urandom);
            r = $urandom_range(0, 1) ? 2'b10 : 2'b00;
            if (i % 2 == 0) begin
                b_resp = r;
                exp_aw.push_back(a); exp_w.push_back({d, s});
                exp_rsp.push_back('{64'd0, r, 1'b0});
                send_cmd(2'd0, a, d, s, 64'd0);
            end else begin
                rq.push_back({r, d});
                exp_rsp.push_back('{d, r, 1'b0});
                send_cmd((i == 3) ? 2'd3 : 2'd1, a, 64'd0, 8'd0, 64'd0);
            end
            wait_rsp("b2b", bl);
            e = exp_rsp.pop_front();
            n_cmp++;
            if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
                n_err++; $display("FAIL b2b_rsp[%0d]: data=%h resp=%b tmo=%b, required %h %b %b",
                                  i, rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
            end
            consume();
        end
        n_cmp++;
        if (obs_aw.size() != exp_aw.size() || obs_w.size() != exp_w.size() || obs_ar.size() != 3) begin
            n_err++; $display("FAIL b2b_beats: aw=%0d w=%0d ar=%0d, required 3 3 3", obs_aw.size(), obs_w.size(), obs_ar.size());
        end else begin
            foreach (exp_aw[i]) begin
                n_cmp++;
                if (obs_aw[i] !== exp_aw[i] || obs_w[i] !== exp_w[i]) begin
                    n_err++; $display("FAIL b2b_write[%0d]: aw=%h w=%h, required %h %h", i, obs_aw[i], obs_w[i], exp_aw[i], exp_w[i]);
                end
            end
        end
        b_resp = 2'b00;
    endtask

    task automatic test_reset_mid();
        rsp_t e;
        int bl, k = 0;
        clear_obs();
        aw_delay = 0; w_delay = 0; b_delay = 40; b_resp = 2'b00;
        send_cmd(2'd0, 32'h30, 64'h1111, 8'hFF, 64'd0);
        while (!bready && k < 50) begin @(negedge clk); k++; end
        n_cmp++;
        if (bready !== 1'b1) begin n_err++; $display("FAIL rstmid_wresp: bready=%b, required 1", bready); end
        rstn = 0;
        @(negedge clk);
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready} !== 8'b00000001) begin
            n_err++; $display("FAIL rstmid_ctrl: got %b, required 00000001",
                              {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready});
        end
        rstn = 1;
        b_delay = 0;
        clear_obs();
        exp_aw.push_back(32'h40);
        exp_w.push_back({64'hCAFE_F00D_1234_5678, 8'h0F});
        exp_rsp.push_back('{64'd0, 2'b00, 1'b0});
        send_cmd(2'd0, 32'h40, 64'hCAFE_F00D_1234_5678, 8'h0F, 64'd0);
        wait_rsp("rstmid", bl);
        e = exp_rsp.pop_front();
        n_cmp++;
        if ({rsp_data, rsp_resp, rsp_timeout} !== {e.data, e.resp, e.tmo}) begin
            n_err++; $display("FAIL rstmid_rsp: data=%h resp=%b tmo=%b, required %h %b %b",
                              rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.tmo);
        end
        n_cmp++;
        if (obs_aw.size() != 1 || obs_w.size() != 1 || obs_aw[0] !== exp_aw[0] || obs_w[0] !== exp_w[0]) begin
            n_err++; $display("FAIL rstmid_beats: aw count=%0d w count=%0d, required one matching beat each",
                              obs_aw.size(), obs_w.size());
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_poll_error_hold();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
